// File: rtl/linear_led_sequencer_if.sv
// linear_led_sequencer_if
//   Pixel stream between the LED sequencer and the LED driver.
//   pixel_rgb   : current pixel {R,G,B}, 3*CH_W bits
//   pixel_valid : pixel_rgb holds a pixel of the frame
//   pixel_ready : driver accepts the presented pixel this cycle
//   pixel_last  : presented pixel is the final pixel of the frame
//   master = sequencer side, slave = driver side.
interface linear_led_sequencer_if #(
  parameter int CH_W = 8
);
  logic [3*CH_W-1:0] pixel_rgb;
  logic              pixel_valid;
  logic              pixel_ready;
  logic              pixel_last;

  modport master (
    output pixel_rgb,
    output pixel_valid,
    output pixel_last,
    input  pixel_ready
  );

  modport slave (
    input  pixel_rgb,
    input  pixel_valid,
    input  pixel_last,
    output pixel_ready
  );
endinterface

// File: rtl/linear_led_sequencer.sv
// linear_led_sequencer
//   Expands one colour per bin and an LED count per bin into a serial
//   stream of exactly LEDS pixels per frame. Bins are emitted in index
//   order, each repeated led_counts[i] times; once all bins are used up
//   the stream is black, and pattern positions at or beyond LEDS are
//   never reached, so oversized count sums truncate the last bins.
//
//   Optional feature macro: LINEAR_LED_SEQ_ROTATE_EN
//     When defined, each completed frame advances a rotation offset by
//     rot_step (mod LEDS) and the next frame starts at that pattern
//     position after a silent SEEK phase. When undefined the offset is
//     always 0, SEEK does not exist and rot_step is ignored.
//
//   Ports
//     clk, rst_n   : clock, asynchronous active-low reset
//     bin_rgb      : colour per bin, captured on frame_start
//     led_counts   : LED count per bin, captured on frame_start
//     rot_step     : rotation advance per frame (optional feature)
//     frame_start  : frame request, sampled only while idle
//     frame_busy   : high from capture until frame_done
//     frame_done   : one-cycle pulse when a frame completes
//     pix          : pixel stream (valid/ready/last), master side
module linear_led_sequencer #(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  parameter int CH_W    = 8,
  parameter int CW      = $clog2(LEDS+1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [BIN_QTY-1:0][3*CH_W-1:0]      bin_rgb,
  input  logic [BIN_QTY-1:0][CW-1:0]          led_counts,
  input  logic [$clog2(LEDS)-1:0]             rot_step,
  input  logic                                frame_start,
  output logic                                frame_busy,
  output logic                                frame_done,
  linear_led_sequencer_if.master              pix
);

  localparam int PW = $clog2(LEDS);
  localparam int BW = $clog2(BIN_QTY+1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef LINEAR_LED_SEQ_ROTATE_EN
    SEEK   = 2'd1,
`endif
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [BIN_QTY-1:0][3*CH_W-1:0] rgb_q, rgb_d;
  logic [BIN_QTY-1:0][CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]                  bin_q, bin_d;
  logic [CW-1:0]                  rep_q, rep_d;
  logic [PW-1:0]                  pos_q, pos_d;
  logic [PW-1:0]                  ocnt_q, ocnt_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           valid_q, valid_d;

  logic [BW-1:0]                  eff_bin;
  logic [CW-1:0]                  eff_cnt;
  logic [3*CH_W-1:0]              pat_rgb;
  logic [BW-1:0]                  adv_bin;
  logic [CW-1:0]                  adv_rep;
  logic [PW-1:0]                  adv_pos;

`ifdef LINEAR_LED_SEQ_ROTATE_EN
  logic [PW-1:0]                  offset_q, offset_d;
  logic [PW-1:0]                  seek_q, seek_d;
  logic [PW-1:0]                  rot_eff;
  logic [PW:0]                    rot_sum;
`else
  logic                           unused_rot;
  assign unused_rot = ^rot_step;
`endif

  // bin_q may point at a zero-count bin; the effective bin is the first
  // nonzero bin at or after it, or BIN_QTY once all bins are exhausted.
  always_comb begin
    eff_bin = BW'(BIN_QTY);
    for (int i = BIN_QTY-1; i >= 0; i--) begin
      if (BW'(i) >= bin_q && cnt_q[i] != '0) eff_bin = BW'(i);
    end
    eff_cnt = '0;
    pat_rgb = '0;
    for (int i = 0; i < BIN_QTY; i++) begin
      if (eff_bin == BW'(i)) begin
        eff_cnt = cnt_q[i];
        pat_rgb = rgb_q[i];
      end
    end
  end

  // Pattern pointer one position ahead; wraps to position 0 after LEDS-1,
  // where the search above lands on the first nonzero bin again.
  always_comb begin
    adv_bin = eff_bin;
    adv_rep = rep_q + 1'b1;
    adv_pos = pos_q + 1'b1;
    if (pos_q == PW'(LEDS-1)) begin
      adv_bin = '0;
      adv_rep = '0;
      adv_pos = '0;
    end else if (eff_bin == BW'(BIN_QTY)) begin
      adv_rep = '0;
    end else if (rep_q + 1'b1 == eff_cnt) begin
      adv_bin = eff_bin + 1'b1;
      adv_rep = '0;
    end
  end

  // Frame control: capture, optional seek, stream, done pulse.
  always_comb begin
    state_d = state_q;
    rgb_d   = rgb_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    rep_d   = rep_q;
    pos_d   = pos_q;
    ocnt_d  = ocnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
`ifdef LINEAR_LED_SEQ_ROTATE_EN
    offset_d = offset_q;
    seek_d   = seek_q;
    rot_eff  = ({1'b0, rot_step} >= (PW+1)'(LEDS)) ? '0 : rot_step;
    rot_sum  = {1'b0, offset_q} + {1'b0, rot_eff};
    if (rot_sum >= (PW+1)'(LEDS)) rot_sum = rot_sum - (PW+1)'(LEDS);
`endif
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          rgb_d  = bin_rgb;
          cnt_d  = led_counts;
          bin_d  = '0;
          rep_d  = '0;
          pos_d  = '0;
          ocnt_d = '0;
          busy_d = 1'b1;
`ifdef LINEAR_LED_SEQ_ROTATE_EN
          if (offset_q != '0) begin
            state_d = SEEK;
            seek_d  = offset_q;
          end else begin
            state_d = STREAM;
            valid_d = 1'b1;
          end
`else
          state_d = STREAM;
          valid_d = 1'b1;
`endif
        end
      end
`ifdef LINEAR_LED_SEQ_ROTATE_EN
      SEEK: begin
        bin_d  = adv_bin;
        rep_d  = adv_rep;
        pos_d  = adv_pos;
        seek_d = seek_q - 1'b1;
        if (seek_q == PW'(1)) begin
          state_d = STREAM;
          valid_d = 1'b1;
        end
      end
`endif
      STREAM: begin
        if (valid_q && pix.pixel_ready) begin
          bin_d = adv_bin;
          rep_d = adv_rep;
          pos_d = adv_pos;
          if (ocnt_q == PW'(LEDS-1)) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            ocnt_d = ocnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef LINEAR_LED_SEQ_ROTATE_EN
        offset_d = rot_sum[PW-1:0];
`endif
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state resets asynchronously, so a reset mid-frame drops the
  // stream at once and no frame_done follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rgb_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      rep_q   <= '0;
      pos_q   <= '0;
      ocnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef LINEAR_LED_SEQ_ROTATE_EN
      offset_q <= '0;
      seek_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rgb_q   <= rgb_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      rep_q   <= rep_d;
      pos_q   <= pos_d;
      ocnt_q  <= ocnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
`ifdef LINEAR_LED_SEQ_ROTATE_EN
      offset_q <= offset_d;
      seek_q   <= seek_d;
`endif
    end
  end

  // The pixel is only driven while valid so idle/reset outputs read 0.
  assign pix.pixel_valid = valid_q;
  assign pix.pixel_rgb   = valid_q ? pat_rgb : '0;
  assign pix.pixel_last  = valid_q && (ocnt_q == PW'(LEDS-1));
  assign frame_busy      = busy_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_linear_led_sequencer.sv
// tb_linear_led_sequencer
//   Directed frames for linear_led_sequencer. Stimulus pushes the expected
//   pixel stream into a queue; a monitor compares every presented pixel
//   against the queue head and pops on acceptance.
module tb_linear_led_sequencer;

  localparam int LEDS    = 50;
  localparam int BIN_QTY = 12;
  localparam int CH_W    = 8;
  localparam int CW      = $clog2(LEDS+1);
  localparam int PW      = $clog2(LEDS);

  typedef struct packed {
    logic [3*CH_W-1:0] rgb;
    logic              last;
  } exp_t;

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b0;
  logic [BIN_QTY-1:0][3*CH_W-1:0]  bin_rgb;
  logic [BIN_QTY-1:0][CW-1:0]      led_counts;
  logic [PW-1:0]                   rot_step;
  logic                            frame_start;
  logic                            frame_busy;
  logic                            frame_done;

  exp_t exp_q[$];
  exp_t head;
  int   exp_idx;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   done_base;

  linear_led_sequencer_if #(.CH_W(CH_W)) pix();

  linear_led_sequencer #(
    .LEDS(LEDS), .BIN_QTY(BIN_QTY), .CH_W(CH_W), .CW(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bin_rgb(bin_rgb),
    .led_counts(led_counts),
    .rot_step(rot_step),
    .frame_start(frame_start),
    .frame_busy(frame_busy),
    .frame_done(frame_done),
    .pix(pix)
  );

  always #5 clk = ~clk;

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(string name, string msg);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s at %0t", name, msg, $time);
  endtask

  // Pixel scoreboard: compare on every presented pixel so stalled pixels
  // must also match the expected head; pop only on acceptance.
  always @(negedge clk) begin
    if (rst_n && pix.pixel_valid) begin
      if (exp_q.size() == 0) begin
        report_fail("pixel_extra", "pixel presented with no expected pixel");
      end else begin
        head = exp_q[0];
        check_output("pixel_rgb", 32'(pix.pixel_rgb), 32'(head.rgb));
        check_output("pixel_last", 32'(pix.pixel_last), 32'(head.last));
        if (pix.pixel_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      done_cnt++;
      check_output("busy_during_done", 32'(frame_busy), 32'd1);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_bins();
    for (int i = 0; i < BIN_QTY; i++) begin
      bin_rgb[i]    = {8'(i + 1), 8'h5A, 8'(3 * i + 7)};
      led_counts[i] = '0;
    end
  endtask

  task automatic push_seg(logic [3*CH_W-1:0] rgb, int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.rgb  = rgb;
      e.last = (exp_idx == LEDS - 1);
      exp_q.push_back(e);
      exp_idx++;
    end
  endtask

  // Pulses frame_start for one cycle; returns just after the sampling edge.
  task automatic apply_stimulus();
    done_base = done_cnt;
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(string name, int bound);
    int n = 0;
    while (done_cnt == done_base && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == done_base) report_fail(name, "frame_done never seen");
    @(posedge clk); #1;
    check_output({name, "_busy_after"}, 32'(frame_busy), 32'd0);
    check_output({name, "_done_after"}, 32'(frame_done), 32'd0);
    check_output({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check_output({name, "_done_count"}, 32'(done_cnt - done_base), 32'd1);
  endtask

  initial begin
    int n;
    frame_start     = 1'b0;
    rot_step        = '0;
    pix.pixel_ready = 1'b1;
    exp_idx         = 0;
    clear_bins();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_valid", 32'(pix.pixel_valid), 32'd0);
    check_output("rst_busy", 32'(frame_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("idle_valid", 32'(pix.pixel_valid), 32'd0);
    check_output("idle_rgb", 32'(pix.pixel_rgb), 32'd0);
    check_output("idle_last", 32'(pix.pixel_last), 32'd0);
    check_output("idle_done", 32'(frame_done), 32'd0);

    // Single bin covering the whole strip, plus first-pixel latency
    clear_bins();
    bin_rgb[0] = 24'hFF0000; led_counts[0] = CW'(50);
    exp_idx = 0; push_seg(24'hFF0000, 50);
    apply_stimulus();
    check_output("t1_latency_valid", 32'(pix.pixel_valid), 32'd1);
    check_output("t1_latency_busy", 32'(frame_busy), 32'd1);
    wait_done("t1", 200);

    // Zero-count bin skipped, black after bins run out
    clear_bins();
    bin_rgb[0] = 24'hFF0000; led_counts[0] = CW'(3);
    bin_rgb[1] = 24'h0000FF;
    bin_rgb[2] = 24'h00FF00; led_counts[2] = CW'(2);
    exp_idx = 0;
    push_seg(24'hFF0000, 3); push_seg(24'h00FF00, 2); push_seg(24'h000000, 45);
    apply_stimulus();
    wait_done("t2", 200);

    // Count sum above LEDS truncates bin1
    clear_bins();
    bin_rgb[0] = 24'h123456; led_counts[0] = CW'(30);
    bin_rgb[1] = 24'h654321; led_counts[1] = CW'(30);
    exp_idx = 0;
    push_seg(24'h123456, 30); push_seg(24'h654321, 20);
    apply_stimulus();
    wait_done("t3", 200);

    // Alternating ready with an ignored frame_start mid-frame
    clear_bins();
    bin_rgb[0] = 24'hA1B2C3; led_counts[0] = CW'(1);
    bin_rgb[1] = 24'h0C0D0E; led_counts[1] = CW'(1);
    bin_rgb[2] = 24'h0000FF; led_counts[2] = CW'(48);
    exp_idx = 0;
    push_seg(24'hA1B2C3, 1); push_seg(24'h0C0D0E, 1); push_seg(24'h0000FF, 48);
    apply_stimulus();
    n = 0;
    while (done_cnt == done_base && n < 400) begin
      @(posedge clk); #1;
      pix.pixel_ready = ~pix.pixel_ready;
      frame_start = (n == 10);
      n++;
    end
    frame_start = 1'b0;
    pix.pixel_ready = 1'b1;
    if (done_cnt == done_base) report_fail("t4", "frame_done never seen");
    repeat (6) @(posedge clk);
    #1;
    check_output("t4_done_count", 32'(done_cnt - done_base), 32'd1);
    check_output("t4_busy_after", 32'(frame_busy), 32'd0);
    check_output("t4_valid_after", 32'(pix.pixel_valid), 32'd0);
    check_output("t4_queue_left", 32'(exp_q.size()), 32'd0);

`ifdef LINEAR_LED_SEQ_ROTATE_EN
    // Rotation by 5 between two frames
    clear_bins();
    bin_rgb[0] = 24'hFF0000; led_counts[0] = CW'(10);
    bin_rgb[1] = 24'h0000FF; led_counts[1] = CW'(40);
    rot_step = PW'(5);
    exp_idx = 0;
    push_seg(24'hFF0000, 10); push_seg(24'h0000FF, 40);
    apply_stimulus();
    check_output("rot1_latency_valid", 32'(pix.pixel_valid), 32'd1);
    wait_done("rot1", 200);
    rot_step = '0;
    exp_idx = 0;
    push_seg(24'hFF0000, 5); push_seg(24'h0000FF, 40); push_seg(24'hFF0000, 5);
    apply_stimulus();
    check_output("rot2_seek_valid", 32'(pix.pixel_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_output("rot2_seek_valid", 32'(pix.pixel_valid), 32'd0);
    end
    @(posedge clk); #1;
    check_output("rot2_first_valid", 32'(pix.pixel_valid), 32'd1);
    wait_done("rot2", 200);
`endif

    // Reset during pixel 20 aborts the frame; a fresh frame follows
    clear_bins();
    bin_rgb[0] = 24'h111111; led_counts[0] = CW'(10);
    bin_rgb[3] = 24'h222222; led_counts[3] = CW'(40);
    exp_idx = 0;
    push_seg(24'h111111, 10); push_seg(24'h222222, 40);
    apply_stimulus();
    n = 0;
    while (exp_q.size() > LEDS - 19 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("rst_mid_progress", 32'(exp_q.size()), 32'(LEDS - 19));
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_mid_valid", 32'(pix.pixel_valid), 32'd0);
    check_output("rst_mid_rgb", 32'(pix.pixel_rgb), 32'd0);
    check_output("rst_mid_last", 32'(pix.pixel_last), 32'd0);
    check_output("rst_mid_busy", 32'(frame_busy), 32'd0);
    check_output("rst_mid_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_no_done", 32'(done_cnt - done_base), 32'd0);
    check_output("rst_idle_valid", 32'(pix.pixel_valid), 32'd0);
    exp_idx = 0;
    push_seg(24'h111111, 10); push_seg(24'h222222, 40);
    apply_stimulus();
    check_output("rst_fresh_valid", 32'(pix.pixel_valid), 32'd1);
    wait_done("rst_fresh", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/linear_led_sequencer.md
Name: linear_led_sequencer

Overview:
- Successor stage to the linear visualizer's LED-count and colour calculation.
- Takes one colour per bin (BIN_QTY entries) and an LED count per bin, and expands them into a serial stream of exactly LEDS pixels for the LED driver.
- Per-frame start/busy/done handshake toward the visualizer; valid/ready/last handshake toward the driver.
- Generalised over LED count, bin count and channel width, with optional per-frame rotation.

Parameters:
- LEDS, 50, number of LEDs per frame (>= 2)
- BIN_QTY, 12, number of colour bins
- CH_W, 8, bits per colour channel; pixel width is 3*CH_W
- CW, $clog2(LEDS+1), width of each per-bin count

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- bin_rgb  input  BIN_QTY x 3*CH_W  colour per bin, {R,G,B}
- led_counts  input  BIN_QTY x CW  LEDs assigned to each bin
- rot_step  input  $clog2(LEDS)  rotation advance per frame; used only with the optional feature
- frame_start  input  1  request a frame; sampled in IDLE only
- frame_busy  output  1  high from capture until frame_done
- frame_done  output  1  one-cycle pulse when a frame completes
- pixel_rgb  output  3*CH_W  current pixel
- pixel_valid  output  1  pixel_rgb is valid
- pixel_ready  input  1  driver accepts the pixel
- pixel_last  output  1  marks pixel LEDS-1 of the frame

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: every output 0, state IDLE, rotation offset 0.
- Reset asserted mid-frame aborts the frame immediately: pixel_valid drops asynchronously and no frame_done is issued.
- FSM states: IDLE, SEEK, STREAM, DONE.
- IDLE:
  - frame_start=1 captures bin_rgb and led_counts into internal registers.
  - Clears the pattern pointer (bin index, repeat count, pattern position) and sets frame_busy.
  - Next state is SEEK if offset!=0, otherwise STREAM.
  - Inputs are not sampled again until the next IDLE.
  - frame_start while busy is ignored, not queued.
- Pattern definition:
  - Bins are emitted in index order 0..BIN_QTY-1, each repeated led_counts[i] times.
  - Zero-count bins consume no pixels; a combinational next-nonzero-bin search runs in the same cycle.
  - After all bins are exhausted, the pattern emits black (0).
  - Pattern positions >= LEDS are never reached, so a count sum greater than LEDS truncates the last bins.
- SEEK:
  - Advances the pattern pointer one position per cycle without output, for offset cycles.
  - Then moves to STREAM.
- STREAM:
  - pixel_valid=1 and pixel_rgb is the pattern pixel at the current position.
  - The pointer advances only on pixel_valid && pixel_ready.
  - While stalled, pixel_rgb and pixel_last are held stable.
  - When the pattern position reaches LEDS-1 and advances, the pointer wraps to pattern position 0, which is the first nonzero bin.
  - An output counter counts accepted pixels; pixel_last=1 while the counter equals LEDS-1.
  - Acceptance of the last pixel moves to DONE.
- DONE:
  - frame_done=1 for one cycle; frame_busy=0 from the following cycle.
  - Updates the rotation offset when the optional feature is compiled in.
  - Returns to IDLE.
- A new frame_start is accepted no earlier than the cycle after DONE.
- Latency with offset 0: frame_start on cycle N gives the first pixel_valid on cycle N+1.
- Minimum frame length with pixel_ready held at 1: 1 + LEDS + 1 cycles, plus offset cycles when seeking.
- Arithmetic:
  - Count comparisons are unsigned, CW bits wide.
  - Position and offset arithmetic is modulo LEDS with no overflow beyond $clog2(LEDS) bits.

Optional Feature:
- Macro: LINEAR_LED_SEQ_ROTATE_EN.
- Enabled:
  - In DONE, offset <= offset+rot_step, minus LEDS when the sum is >= LEDS.
  - rot_step >= LEDS is treated as 0.
  - The next frame's pixel k is pattern[(k+offset) mod LEDS], reached through SEEK.
- Disabled:
  - Offset is a constant 0 and the SEEK state is not built.
  - rot_step is unused.
  - The frame always starts at pattern position 0.

Test Plan:
- bin0 rgb=FF0000, count 50, all other counts 0, pixel_ready=1 -> 50 pixels of FF0000; pixel_last on the 50th; frame_done on the next cycle; frame_busy low after that.
- counts {3,0,2,0...}, rgb0=FF0000, rgb2=00FF00 -> FF0000 x3, 00FF00 x2, then 000000 x45; bin1 contributes nothing.
- counts bin0=30, bin1=30 -> 30 pixels of rgb0, 20 pixels of rgb1; last pixel asserted at 50; bin1 truncated.
- pixel_ready alternating 1/0, with a frame_start pulse mid-frame -> pixel_rgb stable during stalls; exactly 50 pixels accepted; second frame_start ignored; exactly one frame_done.
- With LINEAR_LED_SEQ_ROTATE_EN, rot_step=5, counts bin0=10 (red), bin1=40 (blue):
  - Frame 1 starts with 10 red.
  - Frame 2 first pixel_valid 6 cycles after frame_start, then 5 red, 40 blue, 5 red.
- rst driven low during pixel 20 -> all outputs 0 immediately; after release, a fresh frame streams from pattern position 0 and frame_done pulses exactly once, only for the fresh frame.
